// File: rtl/asrv32_fetch_ctrl.sv
// Instruction fetch controller: issues one word fetch at a time, registers the returned
// instruction for the decoder and handles branch/jump redirects, including in-flight ones.
module asrv32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  input  logic        i_dec_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NopInst        = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StValid, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redirect_target;

  assign redirect_target = {i_redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (i_redirect) pc_d = redirect_target;
      end
      StReq: begin
        if (i_redirect) begin
          pc_d = redirect_target;
          // An unacknowledged request must stay on the bus at its old address.
          if (!i_imem_ack) begin
            hold_addr_d = pc_q;
            state_d     = StFlush;
          end
        end else if (i_imem_ack) begin
          inst_d    = i_imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = StValid;
        end
      end
      StValid: begin
        if (i_redirect) begin
          pc_d    = redirect_target;
          state_d = StReq;
        end else if (i_dec_ready) begin
          state_d = StReq;
        end
      end
      StFlush: begin
        if (i_redirect) pc_d = redirect_target;
        // Stale data is dropped; the redirected fetch starts next cycle.
        if (i_imem_ack) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      pc_q        <= ResetPcAligned;
      hold_addr_q <= 32'h0000_0000;
      inst_q      <= NopInst;
      inst_pc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  assign o_imem_req   = (state_q == StReq) || (state_q == StFlush);
  assign o_imem_addr  = (state_q == StFlush) ? hold_addr_q : pc_q;
  assign o_inst_valid = (state_q == StValid);
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_asrv32_fetch_ctrl.sv
// Bench for asrv32_fetch_ctrl: two instances (reset PC 0 and 0xFFFFFFFC) share stimulus and
// are compared every cycle against a transaction-level model of the fetch unit.
module tb_asrv32_fetch_ctrl;

  localparam logic [31:0] Rp0 = 32'h0000_0000;
  localparam logic [31:0] Rp1 = 32'hFFFF_FFFC;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_dec_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  logic [1:0]  req;
  logic [1:0]  valid;
  logic [31:0] addr    [2];
  logic [31:0] inst    [2];
  logic [31:0] inst_pc [2];

  int checks = 0;
  int errors = 0;
  bit rand_data = 1'b0;

  always #5 i_clk = ~i_clk;

  asrv32_fetch_ctrl #(.RESET_PC(Rp0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(req[0]), .o_imem_addr(addr[0]),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_inst(inst[0]), .o_inst_pc(inst_pc[0]), .o_inst_valid(valid[0]),
    .i_dec_ready(i_dec_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  asrv32_fetch_ctrl #(.RESET_PC(Rp1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(req[1]), .o_imem_addr(addr[1]),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_inst(inst[1]), .o_inst_pc(inst_pc[1]), .o_inst_valid(valid[1]),
    .i_dec_ready(i_dec_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  // Model: a request is outstanding (busy), may be stale (result to be discarded),
  // an instruction may be held for the decoder, or the unit is in its post-reset gap.
  bit          m_known = 1'b0;
  bit          m_start, m_busy, m_stale, m_have;
  logic [31:0] m_pc [2];
  logic [31:0] m_old [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_inst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    if (!m_known) return;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("req%0d", d), {31'b0, req[d]}, {31'b0, m_busy});
      if (m_busy) chk($sformatf("addr%0d", d), addr[d], m_stale ? m_old[d] : m_pc[d]);
      chk($sformatf("valid%0d", d), {31'b0, valid[d]}, {31'b0, m_have});
      chk($sformatf("inst%0d", d), inst[d], m_inst);
      chk($sformatf("inst_pc%0d", d), inst_pc[d], m_ipc[d]);
    end
  endtask

  task automatic model_step(input bit rst, input bit ack, input bit ready, input bit redir,
                            input logic [31:0] rpc, input logic [31:0] rdata);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (rst) begin
      m_known = 1'b1; m_start = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_have = 1'b0;
      m_pc[0] = Rp0; m_pc[1] = Rp1; m_inst = 32'h0000_0013;
      for (int d = 0; d < 2; d++) begin m_ipc[d] = '0; m_old[d] = '0; end
    end else if (!m_known) begin
      return;
    end else if (m_start) begin
      m_start = 1'b0;
      m_busy  = 1'b1;
      if (redir) begin m_pc[0] = tgt; m_pc[1] = tgt; end
    end else if (m_busy) begin
      if (redir) begin
        if (ack) m_stale = 1'b0;
        else if (!m_stale) begin
          m_stale = 1'b1;
          m_old[0] = m_pc[0]; m_old[1] = m_pc[1];
        end
        m_pc[0] = tgt; m_pc[1] = tgt;
      end else if (ack) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          m_inst = rdata;
          for (int d = 0; d < 2; d++) begin
            m_ipc[d] = m_pc[d];
            m_pc[d]  = m_pc[d] + 32'd4;
          end
          m_busy = 1'b0;
          m_have = 1'b1;
        end
      end
    end else if (m_have) begin
      if (redir) begin
        m_have = 1'b0; m_busy = 1'b1; m_pc[0] = tgt; m_pc[1] = tgt;
      end else if (ready) begin
        m_have = 1'b0; m_busy = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit ack, input bit ready, input bit redir,
                     input logic [31:0] rpc);
    logic [31:0] rd;
    check_outputs();
    // Leave redirect-during-flush-completion unexercised.
    if (m_known && m_stale && ack) redir = 1'b0;
    rd = rand_data ? $urandom : (addr[0] ^ 32'hA5A5_0000);
    i_rst = rst; i_imem_ack = ack; i_dec_ready = ready; i_redirect = redir;
    i_redirect_pc = rpc; i_imem_rdata = rd;
    @(posedge i_clk);
    model_step(rst, ack, ready, redir, rpc, rd);
    @(negedge i_clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req[0] && n < 10) begin cyc(1'b0, 1'b0, 1'b0, 1'b0, '0); n++; end
    chk("wait_req", {31'b0, req[0]}, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid[0] && n < 10) begin cyc(1'b0, 1'b1, 1'b0, 1'b0, '0); n++; end
    chk("wait_valid", {31'b0, valid[0]}, 32'd1);
  endtask

  initial begin
    i_rst = 1'b1; i_imem_ack = 1'b0; i_dec_ready = 1'b0; i_redirect = 1'b0;
    i_redirect_pc = '0; i_imem_rdata = '0;
    @(negedge i_clk);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("reset_inst", inst[0], 32'h0000_0013);
    // Zero-wait streaming with a ready decoder; dut1 wraps from 0xFFFFFFFC to 0.
    repeat (12) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    // Delayed ack at 0x10, then a stalled decoder.
    wait_valid();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    // Redirect to 0x103 while a request waits; flush then fetch 0x100.
    wait_req();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    // Redirect coincident with ready in the valid state.
    wait_valid();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    // Acks while no request is outstanding must be ignored.
    wait_valid();
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    // Reset during an outstanding request.
    wait_req();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_req_drop", {31'b0, req[0]}, 32'd0);
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    // Randomized traffic.
    rand_data = 1'b1;
    repeat (500) begin
      cyc($urandom_range(63, 0) == 0, $urandom_range(1, 0) == 1,
          $urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0, $urandom);
    end
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
